// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_pkg
// Purpose : Shared constants, state encoding and the LFSR step function for
//           the lfsr_rng_sched block.
// Contents: c_LFSR_W        default LFSR/data width
//           c_MAX_W         widest LFSR the step function supports
//           c_TAP_MASK      feedback taps {0,2,3,5}
//           c_SEED_DEFAULT  reset seed, also replaces any zero seed
//           state_t         {WARM, RUN}
//           lfsr_next()     one Fibonacci step of a w-bit LFSR
// Revision: 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int c_LFSR_W = 16;
    localparam int c_MAX_W  = 64;

    // Feedback taps at bit positions 0, 2, 3 and 5.
    localparam logic [c_MAX_W-1:0] c_TAP_MASK = 64'h0000_0000_0000_002D;

    localparam logic [15:0] c_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [0:0] {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Right shift with the XOR of the taps entering bit w-1. The caller passes
    // the state zero-extended and truncates the result back to w bits.
    function automatic logic [c_MAX_W-1:0] lfsr_next(
        input logic [c_MAX_W-1:0] q,
        input int                 w
    );
        logic [c_MAX_W-1:0] r;
        logic               fb;
        fb = ^(q & c_TAP_MASK);
        r  = q >> 1;
        for (int i = 0; i < c_MAX_W; i++) begin
            if (i == w - 1) begin
                r[i] = fb;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_rng_sched_arb.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick: first set request bit searching
//           upward from ptr, wrapping from NREQ-1 back to 0.
// Ports   : req    in  NREQ  request vector
//           ptr    in  PW    highest-priority index
//           winner out PW    index of the selected requester
//           valid  out 1     any request present
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            valid
);

    int w_dist;
    int w_best;

    // Each requester's distance from ptr along the wrap-around search order;
    // the smallest distance among active requesters wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_dist = 0;
        w_best = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = j - int'(ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                winner = PW'(j);
                valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_rng_sched.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_rng_sched
// Purpose : Owns a W-bit Fibonacci LFSR and hands its words out to NREQ
//           requesters in round-robin order, one word per grant, after a
//           warm-up of WARMUP free-running steps following every seed.
// Ports   : clk        in  1     rising-edge clock
//           rst        in  1     asynchronous active-high reset
//           seed_load  in  1     load seed_in (highest priority)
//           seed_in    in  W     new seed (zero means SEED_DEFAULT)
//           req        in  NREQ  level requests
//           gnt        out NREQ  one-hot registered grant pulse
//           rnd_valid  out 1     |gnt
//           rnd_data   out W     word delivered with gnt
//           ready      out 1     high in RUN
// Revision: 1.0 - initial release
// ============================================================================
module lfsr_rng_sched
    import lfsr_pkg::*;
#(
    parameter int              W            = c_LFSR_W,
    parameter int              NREQ         = 4,
    parameter int              WARMUP       = 16,
    parameter logic [W-1:0]    SEED_DEFAULT = W'(c_SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [W-1:0]     seed_in,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             rnd_valid,
    output logic [W-1:0]     rnd_data,
    output logic             ready
);

    localparam int     c_PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int     c_CW        = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int     c_WARM_LAST = (WARMUP > 0) ? (WARMUP - 1) : 0;
    localparam state_t c_START     = (WARMUP == 0) ? RUN : WARM;
    localparam logic [NREQ-1:0] c_ONE = NREQ'(1);

    logic [W-1:0]    r_lfsr;
    logic [c_CW-1:0] r_cnt;
    logic [c_PW-1:0] r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [W-1:0]    r_data;
    state_t          r_state;

    logic [W-1:0]    w_next;
    logic [W-1:0]    w_seed;
    logic [c_PW-1:0] w_winner;
    logic            w_valid;
    logic [c_PW-1:0] w_ptr_next;

    assign w_next = W'(lfsr_next(c_MAX_W'(r_lfsr), W));

    // A zero seed would lock the LFSR at zero forever.
    assign w_seed = (seed_in == '0) ? SEED_DEFAULT : seed_in;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (c_PW)
    ) u_arb (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .valid  (w_valid)
    );

    assign w_ptr_next = (w_winner == c_PW'(NREQ - 1)) ? '0 : (w_winner + c_PW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr  <= SEED_DEFAULT;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_data  <= '0;
            r_state <= c_START;
        end else if (seed_load) begin
            // ptr and the last delivered word survive a reseed.
            r_lfsr  <= w_seed;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_state <= c_START;
        end else begin
            case (r_state)
                WARM: begin
                    r_gnt  <= '0;
                    r_lfsr <= w_next;
                    // Leave at the edge that performs the final warm-up step.
                    if (r_cnt == c_CW'(c_WARM_LAST)) begin
                        r_state <= RUN;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                RUN: begin
                    if (w_valid) begin
                        r_gnt  <= c_ONE << w_winner;
                        r_data <= r_lfsr;
                        r_lfsr <= w_next;
                        r_ptr  <= w_ptr_next;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= c_START;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rnd_valid = |r_gnt;
    assign rnd_data  = r_data;
    assign ready     = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rng_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_lfsr_rng_sched
// Purpose : Self-checking bench for lfsr_rng_sched (W=16, NREQ=4, WARMUP=2)
//           with a behavioural reference model and directed + random stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lfsr_rng_sched;

    localparam int W      = 16;
    localparam int NREQ   = 4;
    localparam int WARMUP = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          seed_load = 1'b0;
    logic [W-1:0]  seed_in   = '0;
    logic [3:0]    req       = '0;
    logic [3:0]    gnt;
    logic          rnd_valid;
    logic [W-1:0]  rnd_data;
    logic          ready;

    lfsr_rng_sched #(
        .W            (W),
        .NREQ         (NREQ),
        .WARMUP       (WARMUP),
        .SEED_DEFAULT (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] nxt(input logic [15:0] q);
        return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    endfunction

    logic [15:0] m_lfsr = 16'hACE1;
    int          m_warm = WARMUP;   // steps still to run before grants
    int          m_ptr  = 0;
    logic [3:0]  m_gnt  = '0;
    logic [15:0] m_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr = 16'hACE1;
            m_warm = WARMUP;
            m_ptr  = 0;
            m_gnt  = '0;
            m_data = '0;
        end else if (seed_load) begin
            m_lfsr = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
            m_warm = WARMUP;
            m_gnt  = '0;
        end else if (m_warm > 0) begin
            m_lfsr = nxt(m_lfsr);
            m_warm = m_warm - 1;
            m_gnt  = '0;
        end else if (req != 4'b0) begin
            int win;
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (win < 0 && req[idx]) win = idx;
            end
            m_gnt  = 4'(1 << win);
            m_data = m_lfsr;
            m_lfsr = nxt(m_lfsr);
            m_ptr  = (win + 1) % NREQ;
        end else begin
            m_gnt = '0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [15:0] prev_word = '0;
    bit          prev_ok   = 1'b0;

    always @(negedge clk) begin
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("rnd_valid", 32'(rnd_valid), 32'(m_gnt != 4'b0));
        chk("rnd_data", 32'(rnd_data), 32'(m_data));
        chk("ready", 32'(ready), 32'(m_warm == 0));
        if (rst || m_warm != 0) begin
            prev_ok = 1'b0;
        end else if (gnt != 4'b0) begin
            if (prev_ok) chk("no_repeat", 32'(rnd_data != prev_word), 32'h1);
            prev_word = rnd_data;
            prev_ok   = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] exp_seq [6];

    initial begin
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

        rst = 1'b1;
        repeat (2) tick();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_data", 32'(rnd_data), 32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        rst = 1'b0;
        req = 4'b0001;

        tick();
        chk("ready_warm", 32'(ready), 32'h0);
        tick();
        chk("ready_rise", 32'(ready), 32'h1);
        tick();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_word", 32'(rnd_data), 32'hAB38);
        tick();
        chk("second_word", 32'(rnd_data), 32'h559C);

        // stream: ptr now 1
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_seq", 32'(gnt), 32'(exp_seq[k]));
        end

        // idle, then single requester
        req = 4'b0000;
        repeat (5) begin
            tick();
            chk("idle_gnt", 32'(gnt), 32'h0);
        end
        req = 4'b0100;
        tick();
        chk("after_idle_gnt", 32'(gnt), 32'h4);

        // zero seed mid-stream
        req = 4'b0011;
        repeat (3) tick();
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        tick();
        seed_load = 1'b0;
        chk("seed_gnt", 32'(gnt), 32'h0);
        chk("seed_ready", 32'(ready), 32'h0);
        tick();
        chk("seed_warm_ready", 32'(ready), 32'h0);
        tick();
        chk("seed_ready_rise", 32'(ready), 32'h1);
        tick();
        chk("seed_resume_gnt", 32'(gnt), 32'h2);
        chk("seed_resume_word", 32'(rnd_data), 32'hAB38);

        // asynchronous reset while gnt=0010
        req = 4'b0010;
        tick();
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_valid", 32'(rnd_valid), 32'h0);
        chk("arst_data", 32'(rnd_data), 32'h0);
        chk("arst_ready", 32'(ready), 32'h0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_gnt", 32'(gnt), 32'h2);
        chk("post_rst_word", 32'(rnd_data), 32'hAB38);

        // randomized traffic with occasional reseeds and resets
        for (int i = 0; i < 400; i++) begin
            req       = 4'($urandom);
            seed_load = ($urandom_range(0, 19) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            tick();
            if ($urandom_range(0, 59) == 0) begin
                #2;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        seed_load = 1'b0;
        req       = 4'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
